// File: rtl/data_memory_if.sv
// Block-transfer bus between the data cache (master) and the data memory (slave).
interface data_memory_if;
    logic         read;
    logic         write;
    logic [31:0]  address;
    logic [127:0] writedata;
    logic [127:0] readdata;
    logic         busywait;

    modport master (
        output read, write, address, writedata,
        input  readdata, busywait
    );

    modport slave (
        input  read, write, address, writedata,
        output readdata, busywait
    );
endinterface

// File: rtl/data_memory.sv
// Block-wide data memory with a fixed multi-cycle access latency.
// busywait is raised combinationally in the request cycle and drops together with valid readdata.
module data_memory #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 5
) (
    input  logic          clock,
    input  logic          reset,
    data_memory_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, next_state;
    logic [CNT_W-1:0]   cnt, next_cnt;
    logic               req;
    logic               accept;
    logic               do_access;

    logic [IDX_W-1:0]   idx_q;
    logic [127:0]       wdata_q;
    logic               wr_q;
    logic [127:0]       readdata_q;
    logic [127:0]       mem [DEPTH];

    // Access operands: live bus values when the access coincides with acceptance (LATENCY == 1).
    logic [IDX_W-1:0]   acc_idx;
    logic [127:0]       acc_wdata;
    logic               acc_wr;

    assign req       = bus.read | bus.write;
    assign acc_idx   = accept ? bus.address[IDX_W-1:0] : idx_q;
    assign acc_wdata = accept ? bus.writedata          : wdata_q;
    assign acc_wr    = accept ? bus.write              : wr_q;

    // cnt holds the busy cycles still to come, so the acceptance cycle itself counts
    // towards LATENCY and busywait stays high for exactly LATENCY cycles.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        next_state = state;
        next_cnt   = cnt;
        accept     = 1'b0;
        do_access  = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        do_access  = 1'b1;
                        next_cnt   = '0;
                        next_state = DONE;
                    end else begin
                        next_cnt   = CNT_W'(LATENCY - 1);
                        next_state = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!req) begin
                    next_cnt   = '0;
                    next_state = IDLE;
                end else if (cnt == CNT_W'(1)) begin
                    do_access  = 1'b1;
                    next_cnt   = '0;
                    next_state = DONE;
                end else begin
                    next_cnt   = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_cnt   = '0;
                next_state = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
        end else if (accept) begin
            idx_q   <= bus.address[IDX_W-1:0];
            wdata_q <= bus.writedata;
            wr_q    <= bus.write;
        end
    end

    // NOTE: the array sits under the asynchronous reset because its contents must read as zero after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            readdata_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_access) begin
            if (acc_wr) begin
                mem[acc_idx] <= acc_wdata;
            end else begin
                readdata_q <= mem[acc_idx];
            end
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.busywait = !reset && ((state == BUSY) || ((state == IDLE) && req));

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: a default (LATENCY=5) instance and a LATENCY=1 instance.
module tb_data_memory;
    logic clock = 1'b0;
    logic reset = 1'b1;

    data_memory_if bus0 ();
    data_memory_if bus1 ();

    data_memory #(.DEPTH(256), .LATENCY(5)) dut0 (.clock(clock), .reset(reset), .bus(bus0.slave));
    data_memory #(.DEPTH(256), .LATENCY(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1.slave));

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    logic [127:0] mem0 [256];
    logic [127:0] mem1 [256];
    logic [127:0] rd0 = '0;
    logic [127:0] rd1 = '0;
    logic [127:0] exp_q [$];

    localparam logic [127:0] DATA_W = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] DATA_A = 128'h11112222_33334444_55556666_77778888;
    localparam logic [127:0] DATA_B = 128'hB0B0B0B0_0B0B0B0B_B1B2B3B4_B5B6B7B8;
    localparam logic [127:0] DATA_C = 128'hC0FFEE00_C0FFEE11_C0FFEE22_C0FFEE33;
    localparam logic [127:0] DATA_D = 128'hD00DD00D_D00DD00D_D00DD00D_D00DD00D;
    localparam logic [127:0] DATA_E = 128'hEEEE0000_EEEE1111_EEEE2222_EEEE3333;
    localparam logic [127:0] DATA_F = 128'hF1F2F3F4_F5F6F7F8_F9FAFBFC_FDFEFF00;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [127:0] data);
        if (sel) begin
            bus1.read = rd; bus1.write = wr; bus1.address = addr; bus1.writedata = data;
        end else begin
            bus0.read = rd; bus0.write = wr; bus0.address = addr; bus0.writedata = data;
        end
    endtask

    function automatic logic get_busy(input bit sel);
        return sel ? bus1.busywait : bus0.busywait;
    endfunction

    function automatic logic [127:0] get_rdata(input bit sel);
        return sel ? bus1.readdata : bus0.readdata;
    endfunction

    // Issue one request from a negedge; abort_after>0 drops it after that many busy cycles.
    task automatic run_req(input string tag, input bit sel, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [127:0] data,
                           input int lat, input int abort_after);
        logic [7:0] idx = addr[7:0];
        int n;
        if (abort_after == 0) begin
            if (wr) begin
                if (sel) mem1[idx] = data; else mem0[idx] = data;
            end else begin
                if (sel) rd1 = mem1[idx]; else rd0 = mem0[idx];
            end
        end
        exp_q.push_back(sel ? rd1 : rd0);

        @(negedge clock);
        drive(sel, rd, wr, addr, data);
        #1;
        check({tag, "_busy_first"}, 128'(get_busy(sel)), 128'(1));
        n = 1;

        if (abort_after > 0) begin
            repeat (abort_after - 1) @(negedge clock);
            drive(sel, 1'b0, 1'b0, addr, data);
            @(negedge clock);
            check({tag, "_abort_idle"}, 128'(get_busy(sel)), 128'(0));
            check({tag, "_abort_rdata"}, get_rdata(sel), exp_q.pop_front());
            return;
        end

        while (n < 20) begin
            @(negedge clock);
            // Scramble the bus after acceptance: the latched operands must be used.
            if (n == 1) drive(sel, rd, wr, addr ^ 32'h0000_00A5, ~data);
            if (!get_busy(sel)) break;
            n++;
        end
        check({tag, "_busy_cycles"}, 128'(n), 128'(lat));
        check({tag, "_rdata"}, get_rdata(sel), exp_q.pop_front());
        drive(sel, 1'b0, 1'b0, 32'h0, '0);
        @(negedge clock);
        check({tag, "_idle_after"}, 128'(get_busy(sel)), 128'(0));
    endtask

    task automatic clear_models();
        for (int i = 0; i < 256; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        rd0 = '0;
        rd1 = '0;
    endtask

    initial begin
        clear_models();
        drive(1'b0, 1'b1, 1'b0, 32'h3, '0);
        drive(1'b1, 1'b0, 1'b1, 32'h3, DATA_F);
        repeat (2) @(negedge clock);
        check("rst_busy0", 128'(bus0.busywait), 128'(0));
        check("rst_busy1", 128'(bus1.busywait), 128'(0));
        check("rst_rdata0", bus0.readdata, '0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, '0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, '0);
        reset = 1'b0;

        run_req("rd_after_rst", 1'b0, 1'b1, 1'b0, 32'h3, '0, 5, 0);
        run_req("wr_10", 1'b0, 1'b0, 1'b1, 32'h10, DATA_W, 5, 0);
        run_req("rd_10", 1'b0, 1'b1, 1'b0, 32'h10, '0, 5, 0);
        run_req("wr_05", 1'b0, 1'b0, 1'b1, 32'h05, DATA_A, 5, 0);
        run_req("rd_105", 1'b0, 1'b1, 1'b0, 32'h105, '0, 5, 0);
        run_req("rdwr_20", 1'b0, 1'b1, 1'b1, 32'h20, DATA_B, 5, 0);
        run_req("rd_20", 1'b0, 1'b1, 1'b0, 32'h20, '0, 5, 0);
        run_req("wr_30", 1'b0, 1'b0, 1'b1, 32'h30, DATA_C, 5, 0);
        run_req("abort_30", 1'b0, 1'b0, 1'b1, 32'h30, DATA_D, 5, 2);
        run_req("rd_30", 1'b0, 1'b1, 1'b0, 32'h30, '0, 5, 0);

        run_req("l1_wr_07", 1'b1, 1'b0, 1'b1, 32'h07, DATA_F, 1, 0);
        run_req("l1_rd_07", 1'b1, 1'b1, 1'b0, 32'h07, '0, 1, 0);

        // Reset asserted in the third cycle of a write to 0x40.
        @(negedge clock);
        drive(1'b0, 1'b0, 1'b1, 32'h40, DATA_E);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1;
        check("midrst_busy", 128'(bus0.busywait), 128'(0));
        check("midrst_rdata", bus0.readdata, '0);
        @(negedge clock);
        drive(1'b0, 1'b0, 1'b0, 32'h0, '0);
        reset = 1'b0;
        clear_models();

        run_req("rd_40", 1'b0, 1'b1, 1'b0, 32'h40, '0, 5, 0);
        run_req("rd_10_cleared", 1'b0, 1'b1, 1'b0, 32'h10, '0, 5, 0);
        run_req("l1_rd_07_cleared", 1'b1, 1'b1, 1'b0, 32'h07, '0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
